fp32_mul_result_fifo: RTL and testbench

- Downstream stage for the combinational FP32 multiplier.
- Accepts each 32-bit IEEE-754 product over a valid/ready handshake and classifies it (normal/zero/denormal/inf/NaN).
- Buffers result plus class in a small FIFO and delivers them to the consumer over a second valid/ready handshake.
- Keeps saturating counts of infinity (overflow) and zero (flush/underflow) results for software visibility.

---
 rtl/fp32_mul_result_fifo.sv | 109 ++++++++++
 tb/tb_fp32_mul_result_fifo.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/fp32_mul_result_fifo.sv
// Result FIFO behind the combinational FP32 multiplier: classifies each accepted
// product, buffers word+class, and keeps saturating inf/zero statistics.
module fp32_mul_result_fifo #(
   parameter int DEPTH = 4,
   parameter int CNT_W = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [31:0]              in_data,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [31:0]              out_data,
   output logic [2:0]               out_class,
   output logic [$clog2(DEPTH):0]   level,
   output logic [CNT_W-1:0]         inf_count,
   output logic [CNT_W-1:0]         zero_count,
   input  logic                     clear_counts
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_LEVEL = (AW+1)'(DEPTH);

   localparam logic [2:0] CLS_NORMAL = 3'd0;
   localparam logic [2:0] CLS_ZERO   = 3'd1;
   localparam logic [2:0] CLS_DENORM = 3'd2;
   localparam logic [2:0] CLS_INF    = 3'd3;
   localparam logic [2:0] CLS_NAN    = 3'd4;

   logic [31:0]      data_mem  [DEPTH];
   logic [2:0]       class_mem [DEPTH];
   logic [AW-1:0]    wr_ptr_reg;
   logic [AW-1:0]    rd_ptr_reg;
   logic [AW:0]      level_reg;
   logic [CNT_W-1:0] inf_count_reg;
   logic [CNT_W-1:0] zero_count_reg;
   logic [2:0]       in_class;
   logic             wr_en;
   logic             rd_en;

   always_comb begin
      in_class = CLS_NORMAL;
      if (in_data[30:23] == 8'h00) begin
         in_class = (|in_data[22:0]) ? CLS_DENORM : CLS_ZERO;
      end else if (in_data[30:23] == 8'hFF) begin
         in_class = (|in_data[22:0]) ? CLS_NAN : CLS_INF;
      end
   end

   // in_ready is forced low during reset so no word can slip in while rst is high.
   assign in_ready  = !rst && (level_reg != FULL_LEVEL);
   assign out_valid = (level_reg != '0);
   assign wr_en     = in_valid && in_ready;
   assign rd_en     = out_valid && out_ready;

   assign out_data   = data_mem[rd_ptr_reg];
   assign out_class  = class_mem[rd_ptr_reg];
   assign level      = level_reg;
   assign inf_count  = inf_count_reg;
   assign zero_count = zero_count_reg;

   generate
      for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               data_mem[gi]  <= '0;
               class_mem[gi] <= '0;
            end else if (wr_en && (wr_ptr_reg == AW'(gi))) begin
               data_mem[gi]  <= in_data;
               class_mem[gi] <= in_class;
            end
         end
      end
   endgenerate

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         level_reg  <= '0;
      end else begin
         if (wr_en) wr_ptr_reg <= wr_ptr_reg + AW'(1);
         if (rd_en) rd_ptr_reg <= rd_ptr_reg + AW'(1);
         if (wr_en && !rd_en) begin
            level_reg <= level_reg + (AW+1)'(1);
         end else if (rd_en && !wr_en) begin
            level_reg <= level_reg - (AW+1)'(1);
         end
      end
   end

   // Clear wins over a same-cycle increment; counts stick at all-ones.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         inf_count_reg  <= '0;
         zero_count_reg <= '0;
      end else if (clear_counts) begin
         inf_count_reg  <= '0;
         zero_count_reg <= '0;
      end else if (wr_en) begin
         if ((in_class == CLS_INF) && (inf_count_reg != '1)) begin
            inf_count_reg <= inf_count_reg + CNT_W'(1);
         end
         if ((in_class == CLS_ZERO) && (zero_count_reg != '1)) begin
            zero_count_reg <= zero_count_reg + CNT_W'(1);
         end
      end
   end
endmodule

// File: tb/tb_fp32_mul_result_fifo.sv
// Directed bench for fp32_mul_result_fifo: classification table, fill/drain with
// backpressure, concurrent traffic across pointer wrap, counter saturation and reset.
module tb_fp32_mul_result_fifo;
   localparam int DEPTH = 4;
   localparam int CNT_W = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] in_data = '0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] out_data;
   logic [2:0]  out_class;
   logic [$clog2(DEPTH):0] level;
   logic [CNT_W-1:0] inf_count;
   logic [CNT_W-1:0] zero_count;
   logic        clear_counts = 1'b0;

   fp32_mul_result_fifo #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data), .out_class(out_class),
      .level(level), .inf_count(inf_count), .zero_count(zero_count),
      .clear_counts(clear_counts)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] data;
      logic [2:0]  cls;
   } vec_t;

   vec_t vecs[11];
   int compared   = 0;
   int mismatched = 0;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end else begin
         $display("ok   %s: 0x%08h", name, act);
      end
   endtask

   task automatic clear_stats();
      clear_counts = 1'b1;
      tick();
      clear_counts = 1'b0;
   endtask

   initial begin
      logic [31:0] fw[5];
      logic [2:0]  fc[5];
      logic [31:0] q[$];
      logic        accepted;
      int acc;
      int n;
      int cyc;

      vecs[0]  = '{32'h40400000, 3'd0};
      vecs[1]  = '{32'h00000000, 3'd1};
      vecs[2]  = '{32'h80000000, 3'd1};
      vecs[3]  = '{32'h00000001, 3'd2};
      vecs[4]  = '{32'h7F800000, 3'd3};
      vecs[5]  = '{32'h7FC00000, 3'd4};
      vecs[6]  = '{32'hFF800000, 3'd3};
      vecs[7]  = '{32'h807FFFFF, 3'd2};
      vecs[8]  = '{32'h7F7FFFFF, 3'd0};
      vecs[9]  = '{32'h00800000, 3'd0};
      vecs[10] = '{32'hFF800001, 3'd4};

      // Reset state
      repeat (3) tick();
      chk("rst_level",     32'(level),      32'd0);
      chk("rst_out_valid", 32'(out_valid),  32'd0);
      chk("rst_in_ready",  32'(in_ready),   32'd0);
      chk("rst_out_data",  out_data,        32'd0);
      chk("rst_out_class", 32'(out_class),  32'd0);
      chk("rst_inf_count", 32'(inf_count),  32'd0);
      chk("rst_zero_count",32'(zero_count), 32'd0);
      rst = 1'b0;
      #1;
      chk("post_rst_in_ready", 32'(in_ready), 32'd1);

      // Single-pass classification table
      for (int i = 0; i < 11; i++) begin
         in_valid = 1'b1;
         in_data  = vecs[i].data;
         tick();
         in_valid = 1'b0;
         chk("vec_out_valid", 32'(out_valid), 32'd1);
         chk("vec_out_data",  out_data,       vecs[i].data);
         chk("vec_out_class", 32'(out_class), 32'(vecs[i].cls));
         chk("vec_level",     32'(level),     32'd1);
         out_ready = 1'b1;
         tick();
         out_ready = 1'b0;
         chk("vec_level_after_read", 32'(level), 32'd0);
      end
      chk("table_inf_count",  32'(inf_count),  32'd2);
      chk("table_zero_count", 32'(zero_count), 32'd2);

      // Fill to full, hold the fifth word under backpressure, then drain
      clear_stats();
      fw[0] = 32'h00000000; fc[0] = 3'd1;
      fw[1] = 32'h80000000; fc[1] = 3'd1;
      fw[2] = 32'h00000001; fc[2] = 3'd2;
      fw[3] = 32'h7F800000; fc[3] = 3'd3;
      fw[4] = 32'h7FC00000; fc[4] = 3'd4;
      for (int i = 0; i < 4; i++) begin
         in_valid = 1'b1;
         in_data  = fw[i];
         chk("fill_in_ready", 32'(in_ready), 32'd1);
         tick();
      end
      in_data = fw[4];
      chk("full_in_ready", 32'(in_ready), 32'd0);
      chk("full_level",    32'(level),    32'd4);
      tick();
      tick();
      chk("full_level_held", 32'(level), 32'd4);
      chk("full_head",       out_data,   fw[0]);
      out_ready = 1'b1;
      acc = 0;
      for (int i = 0; i < 5; i++) begin
         chk("drain_out_valid", 32'(out_valid), 32'd1);
         chk("drain_out_data",  out_data,       fw[i]);
         chk("drain_out_class", 32'(out_class), 32'(fc[i]));
         accepted = in_valid && in_ready;
         if (accepted) acc++;
         tick();
         if (accepted) in_valid = 1'b0;
      end
      out_ready = 1'b0;
      chk("held_accept_once", 32'(acc),       32'd1);
      chk("drain_empty",      32'(out_valid), 32'd0);
      chk("drain_level",      32'(level),     32'd0);
      chk("fill_zero_count",  32'(zero_count), 32'd2);
      chk("fill_inf_count",   32'(inf_count),  32'd1);

      // Concurrent read/write at level 2 across pointer wrap
      for (int i = 0; i < 2; i++) begin
         in_valid = 1'b1;
         in_data  = $urandom;
         q.push_back(in_data);
         tick();
      end
      chk("conc_start_level", 32'(level), 32'd2);
      out_ready = 1'b1;
      for (int i = 0; i < 20; i++) begin
         in_data = $urandom;
         chk("conc_out_data", out_data, q[0]);
         void'(q.pop_front());
         q.push_back(in_data);
         tick();
         chk("conc_level", 32'(level), 32'd2);
      end
      in_valid = 1'b0;
      for (int i = 0; i < 2; i++) begin
         chk("conc_tail_data", out_data, q[0]);
         void'(q.pop_front());
         tick();
      end
      out_ready = 1'b0;
      chk("conc_end_level", 32'(level), 32'd0);

      // Counter saturation and clear-over-increment
      clear_stats();
      in_valid  = 1'b1;
      in_data   = 32'hFF800000;
      out_ready = 1'b1;
      n = 0;
      cyc = 0;
      while (n < 17 && cyc < 100) begin
         if (in_ready) n++;
         tick();
         cyc++;
      end
      chk("sat_accepts",   32'(n),         32'd17);
      chk("sat_inf_count", 32'(inf_count), 32'd15);
      clear_counts = 1'b1;
      chk("clear_in_ready", 32'(in_ready), 32'd1);
      tick();
      clear_counts = 1'b0;
      in_valid = 1'b0;
      chk("clear_inf_count", 32'(inf_count), 32'd0);
      cyc = 0;
      while (level != 0 && cyc < 20) begin
         tick();
         cyc++;
      end
      out_ready = 1'b0;
      chk("sat_drained", 32'(level), 32'd0);

      // Reset in the middle of operation with three words stored
      in_valid = 1'b1;
      in_data = 32'h7F800000; tick();
      in_data = 32'h40400000; tick();
      in_data = 32'h00000000; tick();
      in_valid = 1'b0;
      chk("pre_rst_level",     32'(level),     32'd3);
      chk("pre_rst_inf_count", 32'(inf_count), 32'd1);
      rst = 1'b1;
      #1;
      chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
      chk("mid_rst_level",     32'(level),     32'd0);
      chk("mid_rst_inf_count", 32'(inf_count), 32'd0);
      chk("mid_rst_in_ready",  32'(in_ready),  32'd0);
      tick();
      rst = 1'b0;
      out_ready = 1'b1;
      tick();
      tick();
      chk("post_rst_out_valid", 32'(out_valid), 32'd0);
      chk("post_rst_level",     32'(level),     32'd0);
      chk("post_rst_ready",     32'(in_ready),  32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
